ser_tx_logic_port: RTL and testbench

SER_TX_LOGIC_PORT -- requirements
Module: ser_tx_logic_port

---
 rtl/ser_link_pkg.sv | 7 +
 rtl/ser_tx_bit_timer.sv | 19 +
 rtl/ser_tx_logic_port.sv | 109 ++++++++++
 tb/tb_ser_tx_logic_port.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ser_link_pkg.sv
// ser_link_pkg: FSM states and serial line levels shared by the ser link blocks
package ser_link_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ser_state_e;
    localparam logic IDLE_LVL = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/ser_tx_bit_timer.sv
// ser_tx_bit_timer: counts CLKS_PER_BIT cycles per bit and pulses bit_end on the last one
module ser_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic c,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign bit_end = en && cnt_q == LAST;
    always_comb cnt_d = (clr || !en || bit_end) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge c) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/ser_tx_logic_port.sv
// ser_tx_logic_port: registered serial transmitter; define SER_TX_PARITY_EN for an even-parity bit
(* tmr_mode = "default_triplicate" *)
module ser_tx_logic_port
    import ser_link_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              c,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    ser_state_e state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic tx_q, tx_d, ready_q, ready_d, busy_q, busy_d;
    logic accept, bit_end;
`ifdef SER_TX_PARITY_EN
    logic par_q, par_d;
`endif
    assign accept = in_valid && ready_q;
    assign in_ready = ready_q;
    assign tx = tx_q;
    assign busy = busy_q;
    ser_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .c(c), .rst(rst), .clr(accept), .en(busy_q), .bit_end(bit_end)
    );
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d = idx_q;
        tx_d = tx_q;
`ifdef SER_TX_PARITY_EN
        par_d = par_q;
`endif
        if (accept) begin
            state_d = START;
            shift_d = in_data;
            idx_d = '0;
            tx_d = START_LVL;
`ifdef SER_TX_PARITY_EN
            par_d = ^in_data;
`endif
        end else if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    tx_d = shift_q[0];
                end
                DATA: begin
                    if (idx_q == IW'(DATA_W - 1)) begin
`ifdef SER_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d = par_q;
`else
                        state_d = STOP;
                        tx_d = STOP_LVL;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d = shift_d[0];
                    end
                end
`ifdef SER_TX_PARITY_EN
                PARITY: begin
                    state_d = STOP;
                    tx_d = STOP_LVL;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    tx_d = IDLE_LVL;
                end
                default: ;
            endcase
        end
        ready_d = state_d == IDLE;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q <= '0;
            tx_q <= IDLE_LVL;
            ready_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q <= idx_d;
            tx_q <= tx_d;
            ready_q <= ready_d;
            busy_q <= busy_d;
`ifdef SER_TX_PARITY_EN
            par_q <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_ser_tx_logic_port.sv
// tb_ser_tx_logic_port: randomized frame checks against a bit-list reference model
module tb_ser_tx_logic_port;
    localparam int DATA_W = 8;
    localparam int CPB = 4;
`ifdef SER_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = DATA_W + 2 + P;
    localparam int F = NB * CPB;
    logic c = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic in_ready, tx, busy;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 c = ~c;
    ser_tx_logic_port #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .c(c), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy)
    );
    function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return w[b-1];
        if (P == 1 && b == DATA_W + 1) return ^w;
        return 1'b1;
    endfunction
    task automatic wait_ready(input string tag);
        int g = 0;
        while (in_ready !== 1'b1 && g < 100) begin
            @(negedge c);
            g++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_timeout: in_ready=%b, required 1", tag, in_ready);
        end
    endtask
    task automatic run_frame(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] alt, input bit rnd, input string tag);
        logic e;
        wait_ready(tag);
        in_data = w;
        in_valid = 1'b1;
        @(negedge c);
        for (int k = 0; k < F; k++) begin
            e = frame_bit(w, k / CPB);
            n_cmp++;
            if (tx !== e || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s cycle %0d: tx=%b busy=%b in_ready=%b, required %b 1 0", tag, k, tx, busy, in_ready, e);
            end
            in_data = rnd ? DATA_W'($urandom) : alt;
            in_valid = k < F - 1 ? 1'($urandom) : 1'b0;
            @(negedge c);
        end
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle: tx=%b busy=%b in_ready=%b, required 1 0 1", tag, tx, busy, in_ready);
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = DATA_W'($urandom);
        repeat (3) begin
            @(negedge c);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL reset: tx=%b busy=%b in_ready=%b, required 1 0 0", tx, busy, in_ready);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge c);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_release: tx=%b busy=%b in_ready=%b, required 1 0 1", tx, busy, in_ready);
            end
        end
    endtask
    task automatic test_frames();
        run_frame(8'hA5, 8'hA5, 1'b0, "a5");
        run_frame(8'h01, 8'h01, 1'b0, "x01");
        run_frame(8'h55, 8'hAA, 1'b0, "hold55");
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge c);
            run_frame(DATA_W'($urandom), '0, 1'b1, "random");
        end
    endtask
    task automatic test_back_to_back();
        logic e;
        int first = -1;
        int second = -1;
        int rdy = 0;
        wait_ready("b2b");
        in_data = 8'h3C;
        in_valid = 1'b1;
        for (int k = 0; k < 2 * F + 1; k++) begin
            @(negedge c);
            if (k == 0) in_data = 8'hC3;
            if (k == F + 1) in_valid = 1'b0;
            e = k < F ? frame_bit(8'h3C, k / CPB) : k == F ? 1'b1 : frame_bit(8'hC3, (k - F - 1) / CPB);
            n_cmp++;
            if (tx !== e || in_ready !== (k == F) || busy !== (k != F)) begin
                n_bad++;
                $display("FAIL b2b cycle %0d: tx=%b in_ready=%b busy=%b, required %b %b %b", k, tx, in_ready, busy, e, k == F, k != F);
            end
            if (tx === 1'b0 && first < 0) first = k;
            if (tx === 1'b0 && k >= F && second < 0) second = k;
            if (in_ready === 1'b1 && first >= 0 && second < 0) rdy++;
        end
        n_cmp++;
        if (second - first != F + 1 || rdy != 1) begin
            n_bad++;
            $display("FAIL b2b period: gap=%0d ready_cycles=%0d, required %0d 1", second - first, rdy, F + 1);
        end
    endtask
    task automatic test_mid_reset();
        wait_ready("mid_rst");
        in_data = 8'hFF;
        in_valid = 1'b1;
        @(negedge c);
        in_valid = 1'b0;
        repeat (3 * CPB + 1) @(negedge c);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst pre: tx=%b busy=%b, required 1 1", tx, busy);
        end
        rst = 1'b1;
        @(negedge c);
        rst = 1'b0;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst abort: tx=%b busy=%b in_ready=%b, required 1 0 0", tx, busy, in_ready);
        end
        @(negedge c);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst recover: tx=%b busy=%b in_ready=%b, required 1 0 1", tx, busy, in_ready);
        end
        run_frame(8'h00, 8'h00, 1'b0, "after_rst");
    endtask
    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
